fp_add_sub_param: RTL and testbench

FP_ADD_SUB_PARAM -- requirements
Module: fp_add_sub_param

---
 rtl/fp_add_sub_param.sv | 167 ++++++++++++++++
 tb/tb_fp_add_sub_param.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fp_add_sub_param.sv
// Multi-cycle floating-point adder/subtractor (flush-to-zero, sequential align/normalise).
// Define FPU_ROUND_EN for round-to-nearest-even; otherwise ROUND truncates.
module fp_add_sub_param #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   addSub,
    input  logic [EXP_W+MAN_W:0]   X,
    input  logic [EXP_W+MAN_W:0]   Y,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [1:0]             OFUF
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int M = MAN_W + 5;   // {carry, hidden, fraction, guard, round, sticky}
    localparam int E = EXP_W + 1;   // one bit of headroom so overflow never wraps
    localparam logic [E-1:0] EMAX     = {1'b0, {EXP_W{1'b1}}};
    localparam logic [E-1:0] FOLD_LIM = E'(MAN_W + 3);

    typedef enum logic [2:0] {IDLE, CHECK, ALIGN, ADD, NORM, ROUND} state_t;
    state_t state, state_nxt;

    logic [W-1:0]       xr, yr;
    logic               sub_r, sa, sb, zflag, uflag;
    logic [E-1:0]       ea, eb, diff;
    logic [M-1:0]       ma, mb, sum;
    logic [EXP_W-1:0]   x_exp, y_exp;
    logic [MAN_W-1:0]   x_frac, y_frac;
    logic               y_sign_eff, x_zero, y_zero, x_ge;
    logic               inc, rnd_carry, ovf, round_again;
    logic [MAN_W+1:0]   rnd;

    assign x_exp      = xr[W-2:MAN_W];
    assign y_exp      = yr[W-2:MAN_W];
    assign x_frac     = xr[MAN_W-1:0];
    assign y_frac     = yr[MAN_W-1:0];
    assign y_sign_eff = yr[W-1] ^ sub_r;
    assign x_zero     = (x_exp == '0);
    assign y_zero     = (y_exp == '0);
    assign x_ge       = (xr[W-2:0] >= yr[W-2:0]);
    assign diff       = ea - eb;
    assign sum        = (sa == sb) ? ma + mb : ma - mb;

`ifdef FPU_ROUND_EN
    assign inc = ma[2] & (ma[1] | ma[0] | ma[3]);
`else
    assign inc = 1'b0;
`endif
    assign rnd         = ma[M-1:3] + {{(MAN_W+1){1'b0}}, inc};
    assign rnd_carry   = rnd[MAN_W+1];
    assign ovf         = (ea >= EMAX);
    // A rounding carry costs one extra ROUND cycle, then overflow is rechecked.
    assign round_again = !zflag && !uflag && !ovf && rnd_carry;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = CHECK;
            CHECK: begin
                if (x_zero || y_zero)    state_nxt = IDLE;
                else if (x_exp == y_exp) state_nxt = ADD;
                else                     state_nxt = ALIGN;
            end
            ALIGN: if (diff > FOLD_LIM || diff == E'(1)) state_nxt = ADD;
            ADD:   state_nxt = (sum == '0) ? ROUND : NORM;
            NORM:  if (!ma[M-1] && (ma[M-2] || ea <= E'(1))) state_nxt = ROUND;
            ROUND: if (!round_again) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Datapath carries no reset; operands load only on an accepted start.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (start && reset) begin
                xr    <= X;
                yr    <= Y;
                sub_r <= addSub;
            end
            CHECK: begin
                zflag <= 1'b0;
                uflag <= 1'b0;
                if (x_ge) begin
                    sa <= xr[W-1];    ea <= {1'b0, x_exp}; ma <= {2'b01, x_frac, 3'b000};
                    sb <= y_sign_eff; eb <= {1'b0, y_exp}; mb <= {2'b01, y_frac, 3'b000};
                end else begin
                    sa <= y_sign_eff; ea <= {1'b0, y_exp}; ma <= {2'b01, y_frac, 3'b000};
                    sb <= xr[W-1];    eb <= {1'b0, x_exp}; mb <= {2'b01, x_frac, 3'b000};
                end
            end
            ALIGN: begin
                if (diff > FOLD_LIM) begin
                    mb <= {{(M-1){1'b0}}, |mb};
                    eb <= ea;
                end else begin
                    mb <= {1'b0, mb[M-1:2], |mb[1:0]};
                    eb <= eb + E'(1);
                end
            end
            ADD: begin
                ma    <= sum;
                zflag <= (sum == '0);
            end
            NORM: begin
                if (ma[M-1]) begin
                    ma <= {1'b0, ma[M-1:2], |ma[1:0]};
                    ea <= ea + E'(1);
                end else if (!ma[M-2]) begin
                    if (ea <= E'(1)) begin
                        uflag <= 1'b1;
                    end else begin
                        ma <= {ma[M-2:0], 1'b0};
                        ea <= ea - E'(1);
                    end
                end
            end
            ROUND: if (round_again) begin
                ma <= {1'b0, rnd, 2'b00};
                ea <= ea + E'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            done   <= 1'b0;
            result <= '0;
            OFUF   <= 2'b00;
        end else begin
            done <= 1'b0;
            if (state == CHECK && (x_zero || y_zero)) begin
                done <= 1'b1;
                OFUF <= 2'b00;
                if (x_zero && y_zero) result <= '0;
                else if (x_zero)      result <= {y_sign_eff, yr[W-2:0]};
                else                  result <= xr;
            end
            if (state == ROUND && !round_again) begin
                done <= 1'b1;
                if (zflag) begin
                    result <= '0;
                    OFUF   <= 2'b00;
                end else if (uflag) begin
                    result <= {sa, {(W-1){1'b0}}};
                    OFUF   <= 2'b01;
                end else if (ovf) begin
                    result <= {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    OFUF   <= 2'b10;
                end else begin
                    result <= {sa, ea[EXP_W-1:0], rnd[MAN_W-1:0]};
                    OFUF   <= 2'b00;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_add_sub_param.sv
// Directed bench for fp_add_sub_param at EXP_W=5, MAN_W=10 (half precision layout).
module tb_fp_add_sub_param;
    logic        clk = 1'b0;
    logic        reset, start, addSub;
    logic [15:0] X, Y;
    logic        busy, done;
    logic [15:0] result;
    logic [1:0]  OFUF;

    int errors = 0;
    int checks = 0;

`ifdef FPU_ROUND_EN
    localparam logic [15:0] R_ODD   = 16'h3C02;
    localparam logic [15:0] R_CARRY = 16'h4000;
    localparam int          L_CARRY = 16;
`else
    localparam logic [15:0] R_ODD   = 16'h3C01;
    localparam logic [15:0] R_CARRY = 16'h3FFF;
    localparam int          L_CARRY = 15;
`endif

    fp_add_sub_param #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .addSub(addSub),
        .X(X), .Y(Y), .busy(busy), .done(done), .result(result), .OFUF(OFUF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // elat < 0 skips the latency check; glitch pulses a second start 2 cycles in.
    task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic op, input logic [15:0] er, input logic [1:0] eo,
                          input int elat, input bit glitch);
        int cnt;
        bit seen;
        @(posedge clk); #1;
        X = xv; Y = yv; addSub = op; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        cnt = 0; seen = 1'b0;
        while (cnt < 100 && !seen) begin
            if (glitch && cnt == 1) begin
                X = 16'h4000; Y = 16'h4000; addSub = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            seen = done;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " result"}, 32'(result), 32'(er));
            check({tag, " OFUF"}, 32'(OFUF), 32'(eo));
            if (elat >= 0) check({tag, " latency"}, 32'(cnt), 32'(elat));
            @(posedge clk); #1;
            check({tag, " done pulse"}, 32'(done), 32'd0);
            check({tag, " idle"}, 32'(busy), 32'd0);
            check({tag, " held"}, 32'(result), 32'(er));
        end
    endtask

    initial begin
        int cnt;
        bit seen;
        reset = 1'b0; start = 1'b0; addSub = 1'b0; X = '0; Y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset OFUF", 32'(OFUF), 32'd0);
        reset = 1'b1;

        run_op("1+1",        16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00, 5, 1'b0);
        run_op("1-1",        16'h3C00, 16'h3C00, 1'b1, 16'h0000, 2'b00, -1, 1'b0);
        run_op("ovf",        16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 2'b10, 5, 1'b0);
        run_op("unf",        16'h0401, 16'h0400, 1'b1, 16'h0000, 2'b01, -1, 1'b0);
        run_op("round odd",  16'h3C01, 16'h1000, 1'b0, R_ODD,    2'b00, 15, 1'b0);
        run_op("round tie",  16'h3C00, 16'h1000, 1'b0, 16'h3C00, 2'b00, 15, 1'b0);
        run_op("round cry",  16'h3FFF, 16'h1000, 1'b0, R_CARRY,  2'b00, L_CARRY, 1'b0);
        run_op("2-1",        16'h4000, 16'h3C00, 1'b1, 16'h3C00, 2'b00, 6, 1'b0);
        run_op("1+-1.5",     16'h3C00, 16'hBE00, 1'b0, 16'hB800, 2'b00, 5, 1'b0);
        run_op("x zero",     16'h0000, 16'h3C00, 1'b1, 16'hBC00, 2'b00, 1, 1'b0);
        run_op("y zero",     16'h4200, 16'h0000, 1'b0, 16'h4200, 2'b00, 1, 1'b0);
        run_op("both zero",  16'h8000, 16'h8000, 1'b0, 16'h0000, 2'b00, 1, 1'b0);
        run_op("ignore start", 16'h3C01, 16'h1000, 1'b0, R_ODD,  2'b00, 15, 1'b1);

        // Abort while ALIGN is still shifting.
        @(posedge clk); #1;
        X = 16'h3C01; Y = 16'h1000; addSub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort pre busy", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort result", 32'(result), 32'd0);
        check("abort OFUF", 32'(OFUF), 32'd0);
        seen = done;
        for (cnt = 0; cnt < 20; cnt++) begin
            @(posedge clk); #1;
            seen = seen | done;
        end
        check("abort no done", 32'(seen), 32'd0);

        run_op("after abort", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00, 5, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
